// File: rtl/shift_result_stage_pkg.sv
// Shared constants for the shift result stage: op and state encodings, widths.
package shift_result_stage_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;

    localparam logic SHIFT_SLL = 1'b0;
    localparam logic SHIFT_SRA = 1'b1;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

endpackage

// File: rtl/skid_buffer_2.sv
// Generic 2-entry valid/ready buffer: main entry drives the output, skid absorbs one overflow.
// Handshake: a transfer happens on a rising edge when valid and ready are both high; ready is registered.
module skid_buffer_2
    import shift_result_stage_pkg::*;
#(
    parameter int W = 38
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_payload,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_payload
);

    // state is observable by hierarchical reference for debug and checkers
    logic [1:0]   state;
    logic [1:0]   state_next;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic         ready_q;
    logic         in_xfer;
    logic         out_xfer;

    assign in_xfer     = in_valid & ready_q;
    assign out_xfer    = (state != ST_EMPTY) & out_ready;
    assign in_ready    = ready_q;
    assign out_valid   = (state != ST_EMPTY);
    assign out_payload = main_q;

    always_comb begin
        state_next = state;
        case (state)
            ST_EMPTY: if (in_xfer) state_next = ST_ONE;
            ST_ONE: begin
                if (in_xfer && !out_xfer)      state_next = ST_FULL;
                else if (!in_xfer && out_xfer) state_next = ST_EMPTY;
            end
            ST_FULL:  if (out_xfer) state_next = ST_ONE;
            default:  state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_EMPTY;
            ready_q <= 1'b0;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state   <= state_next;
            ready_q <= (state_next != ST_FULL);
            // main takes fresh input when it is free or being drained this edge
            if ((state == ST_EMPTY && in_xfer) || (state == ST_ONE && in_xfer && out_xfer)) begin
                main_q <= in_payload;
            end else if (state == ST_FULL && out_xfer) begin
                main_q <= skid_q;
            end
            if (state == ST_ONE && in_xfer && !out_xfer) begin
                skid_q <= in_payload;
            end
        end
    end

endmodule

// File: rtl/sll_barrel_shifter.sv
// 32-bit logical left barrel shifter; vacated low bits are zero-filled.
module sll_barrel_shifter (
    input  logic [31:0] data,
    input  logic [4:0]  shamt,
    output logic [31:0] result
);

    logic [31:0] stage;

    always_comb begin
        stage = data;
        for (int i = 0; i < 5; i++) begin
            if (shamt[i]) begin
                stage = stage << (32'd1 << i);
            end
        end
        result = stage;
    end

endmodule

// File: rtl/sra_barrel_shifter.sv
// 32-bit arithmetic right barrel shifter; vacated high bits copy bit 31.
module sra_barrel_shifter (
    input  logic [31:0] data,
    input  logic [4:0]  shamt,
    output logic [31:0] result
);

    logic [31:0] stage;

    always_comb begin
        stage = data;
        for (int i = 0; i < 5; i++) begin
            if (shamt[i]) begin
                stage = $unsigned($signed(stage) >>> (32'd1 << i));
            end
        end
        result = stage;
    end

endmodule

// File: rtl/shift_result_stage.sv
// Execute-stage wrapper: shifts on input transfer and buffers {result, tag, zero}
// in a 2-entry skid buffer so downstream stalls never lose or repeat a result.
module shift_result_stage
    import shift_result_stage_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int TAG_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic               in_op,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag,
    output logic               out_zero
);

    localparam int PAYLOAD_W = WIDTH + TAG_W + 1;

    logic [WIDTH-1:0]     sll_result;
    logic [WIDTH-1:0]     sra_result;
    logic [WIDTH-1:0]     shift_result;
    logic [PAYLOAD_W-1:0] in_payload;
    logic [PAYLOAD_W-1:0] out_payload;

    sll_barrel_shifter u_sll (
        .data   (in_data),
        .shamt  (in_shamt),
        .result (sll_result)
    );

    sra_barrel_shifter u_sra (
        .data   (in_data),
        .shamt  (in_shamt),
        .result (sra_result)
    );

    assign shift_result = (in_op == SHIFT_SRA) ? sra_result : sll_result;
    assign in_payload   = {shift_result, in_tag, (shift_result == '0)};

    skid_buffer_2 #(
        .W (PAYLOAD_W)
    ) u_buf (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_payload  (in_payload),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_payload (out_payload)
    );

    assign {out_data, out_tag, out_zero} = out_payload;

endmodule

// File: doc/shift_result_stage.md
Name: shift_result_stage

Overview:
- Registered execute-stage wrapper around the ALU left and right barrel shifters.
- Accepts shift operations on a valid/ready handshake and computes the result combinationally through sll_barrel_shifter or sra_barrel_shifter.
- Captures each result into a 2-entry skid buffer so downstream back-pressure never drops or duplicates a result.
- Sits between operand issue and the writeback/result mux of the processor ALU.

Parameters:
- WIDTH, 32, data width; fixed at 32 to match the shifter cores (5-bit shift amount).
- TAG_W, 5, width of the destination-register tag carried alongside each result.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high.
- in_valid  input  1  upstream offers an operation this cycle.
- in_ready  output  1  stage can accept this cycle.
- in_data  input  32  operand to shift.
- in_shamt  input  5  shift amount, 0..31.
- in_op  input  1  0 = sll, 1 = sra.
- in_tag  input  TAG_W  destination tag, passed through unchanged.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  32  shifted result.
- out_tag  output  TAG_W  tag of out_data.
- out_zero  output  1  out_data == 0.

Behaviour:
- Clock and reset: one clock, clock. reset is synchronous and active-high, sampled only on the rising edge.
- Reset values:
  - State EMPTY; out_valid=0, out_data=0, out_tag=0, out_zero=0.
  - in_ready=0 while reset is high; in_ready=1 from the first cycle after reset deasserts.
- Transfers:
  - Input transfer = in_valid & in_ready at the rising edge.
  - Output transfer = out_valid & out_ready at the rising edge.
- Datapath:
  - Shift result = in_op ? sra(in_data, in_shamt) : sll(in_data, in_shamt), computed combinationally in the same cycle as the input transfer.
  - sll fills zeros. sra replicates bit 31.
  - in_shamt=0 passes in_data unchanged.
- Entries: main (drives the outputs) and skid (holds overflow). Each entry stores {data, tag, zero}.
- Latency: 1 cycle. A result is on out_* the cycle after its input transfer when the stage was EMPTY.
- State machine (in_ready = state != FULL, registered):
  - EMPTY, in xfer -> ONE; main loaded.
  - ONE, in xfer without out xfer -> FULL; new result goes to skid.
  - ONE, out xfer without in xfer -> EMPTY.
  - ONE, in xfer with out xfer -> ONE; main reloaded with the new result.
  - FULL, out xfer -> ONE; skid moves to main.
  - FULL never accepts input (in_ready=0).
- Ordering: results leave strictly in acceptance order.
- Stability: out_data, out_tag and out_zero are held stable while out_valid=1 and out_ready=0.
- Outputs when empty: out_valid=0 exactly in EMPTY. out_data holds its last value, but it is don't-care to consumers.
- Reset mid-operation: any buffered results are discarded, with no output transfer in the reset cycle.
- No combinational path from out_ready to in_ready.
- Protocol checks: in_valid high with in_ready low is legal; upstream must hold its inputs stable until the transfer.

Decomposition:
- Shared package:
  - Op encodings SHIFT_SLL=1'b0, SHIFT_SRA=1'b1.
  - State encodings ST_EMPTY, ST_ONE, ST_FULL.
  - WIDTH and shift-amount width constants.
- Shifter cores: instantiate the existing sll_barrel_shifter and sra_barrel_shifter unchanged.
- Sub-module: one natural sub-module, skid_buffer_2 (generic 2-entry valid/ready buffer, payload width = 32+TAG_W+1), reusable for other ALU result paths.

Test Plan:
- Reset then single sll: in_data=0x00000001, shamt=31, op=0, out_ready=1 -> next cycle out_valid=1, out_data=0x80000000, out_zero=0; following cycle out_valid=0.
- sra sign fill: in_data=0x80000000, shamt=4, op=1, tag=7 -> out_data=0xF8000000, out_tag=7. Then in_data=0x7FFFFFFF, shamt=31 -> out_data=0x00000000, out_zero=1.
- Back-pressure: out_ready=0, send tags 1 and 2 -> in_ready drops after the second transfer and a third offer is stalled. Raise out_ready -> tags 1, 2, 3 emerge in order with no duplicates.
- Streaming: in_valid=1 and out_ready=1 for 8 cycles, shamt 0..7 on data 0xA5A5A5A5 -> one result per cycle, latency 1; shamt=0 returns 0xA5A5A5A5.
- Reset in FULL: assert reset for 1 cycle with two results buffered -> out_valid=0 and in_ready=0 that cycle; in_ready=1 the next cycle; no stale results appear afterwards.
- Random soak: random valid/ready/op/shamt against a reference model -> exact data/tag/order match and out_* stable while stalled.
